// File: rtl/fetch_align_buf.sv
// Purpose : instruction fetch buffer that turns 8-byte fetch words into aligned
//           RV16/RV32 instructions, with a 2-entry word FIFO and redirect flush.
// Latency : a fetched word reaches out_valid the cycle after its mem_rvalid beat.
// Backpr. : out_ready low holds the presented instruction; fetching stops once
//           buffered words plus outstanding requests reach 2.
// Ports   : clk/rst (async, active-high); redirect/redirect_pc;
//           mem_req/mem_addr/mem_ready request side, mem_rvalid/mem_rdata response side;
//           out_valid/out_ready/out_pc/out_instr/out_isrv16 instruction output.
module fetch_align_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_isrv16
);

  // Word FIFO: entry 0 is always the head; entry 1 shifts down on pop.
  logic [63:0] ent_dat [2];
  logic [31:3] ent_tag [2];
  logic [1:0]  cnt;         // valid entries
  logic [1:0]  outst;       // in-flight requests, including ones marked for drop
  logic [1:0]  drop;        // leading in-flight beats that belong to a flushed stream
  logic [1:0]  hw_off;      // halfword offset of out_pc inside the head word
  logic [31:0] pc_q;
  logic [31:3] fetch_addr;  // next word to request
  logic [31:3] rsp_addr;    // word address of the next kept response

  logic [31:0] instr;
  logic        rv16;
  logic        accept;
  logic        rsp_take;
  logic        rsp_wr;
  logic        consume;
  logic        pop;
  logic [2:0]  hw_sum;
  logic [1:0]  wr_pos;
  logic        wr_sel;

  // hw_off 3 is the only case where an instruction can straddle two words.
  always_comb begin
    unique case (hw_off)
      2'd0:    instr = ent_dat[0][31:0];
      2'd1:    instr = ent_dat[0][47:16];
      2'd2:    instr = ent_dat[0][63:32];
      default: instr = {ent_dat[1][15:0], ent_dat[0][63:48]};
    endcase
  end

  assign rv16       = (instr[1:0] != 2'b11);
  assign out_instr  = instr;
  assign out_isrv16 = rv16;
  assign out_pc     = pc_q;
  assign mem_addr   = {fetch_addr, 3'b000};

  // Purely register-driven: no path from out_ready or mem_rvalid.
  assign out_valid = (cnt != 2'd0) && (rv16 || (hw_off != 2'd3) || (cnt == 2'd2));

  assign mem_req = !rst && !redirect && (({1'b0, cnt} + {1'b0, outst}) < 3'd2);
  assign accept  = mem_req && mem_ready;

  // A beat with nothing outstanding (e.g. one in flight across a reset) is ignored.
  assign rsp_take = mem_rvalid && (outst != 2'd0);
  assign rsp_wr   = rsp_take && (drop == 2'd0) && !redirect;

  assign consume = out_valid && out_ready && !redirect;
  assign hw_sum  = {1'b0, hw_off} + (rv16 ? 3'd1 : 3'd2);
  assign pop     = consume && hw_sum[2];

  // Tail slot seen after this cycle's pop; cnt==2 never coincides with a write.
  assign wr_pos = cnt - {1'b0, pop};
  assign wr_sel = (wr_pos != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      outst      <= 2'd0;
      drop       <= 2'd0;
      hw_off     <= RESET_PC[2:1];
      pc_q       <= RESET_PC;
      fetch_addr <= RESET_PC[31:3];
      rsp_addr   <= RESET_PC[31:3];
    end else begin
      outst <= outst + {1'b0, accept} - {1'b0, rsp_take};
      if (redirect) begin
        // Everything still in flight belongs to the old stream; a beat landing
        // this cycle is already retired from outst here.
        cnt        <= 2'd0;
        drop       <= outst - {1'b0, rsp_take};
        hw_off     <= redirect_pc[2:1];
        pc_q       <= redirect_pc & ~32'd1;
        fetch_addr <= redirect_pc[31:3];
        rsp_addr   <= redirect_pc[31:3];
      end else begin
        if (accept)
          fetch_addr <= fetch_addr + 29'd1;
        if (rsp_take && (drop != 2'd0))
          drop <= drop - 2'd1;
        if (rsp_wr)
          rsp_addr <= rsp_addr + 29'd1;
        if (consume) begin
          pc_q   <= pc_q + (rv16 ? 32'd2 : 32'd4);
          hw_off <= hw_sum[1:0];
        end
        cnt <= cnt - {1'b0, pop} + {1'b0, rsp_wr};
      end
    end
  end

  // Payload storage needs no reset: cnt qualifies every read.
  always_ff @(posedge clk) begin
    if (pop) begin
      ent_dat[0] <= ent_dat[1];
      ent_tag[0] <= ent_tag[1];
    end
    if (rsp_wr) begin
      ent_dat[wr_sel] <= mem_rdata;
      ent_tag[wr_sel] <= rsp_addr;
    end
  end

  // The head word must always be the word containing out_pc.
  head_tag_matches_pc: assert property (@(posedge clk) disable iff (rst)
    (cnt != 2'd0) |-> (ent_tag[0] == pc_q[31:3]));

endmodule
